osc_window_hyst: RTL

Measurement back-end of the ring-oscillator temperature sensor. Counts synchronised oscillator pulses over a fixed window of system-clock cycles, publishes each window's count, and drives a debounced hysteretic over-temperature flag. Sits directly downstream of the oscillator select/synchroniser stage. Its `count_out` feeds the `uio_out` count bus and the UART reporter; its `temp_warn` drives `uo_out[1]`.

---
 rtl/osc_window_hyst.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/osc_window_hyst.sv
// osc_window_hyst
// Measurement back-end of the ring-oscillator temperature sensor.
// Counts synchronised oscillator pulses over a window of 2^WIN_LOG2 clk
// cycles, publishes each completed window count and drives a debounced,
// hysteretic over-temperature flag (hot = slower oscillator = lower count).
//
// Parameters:
//   CNT_W    width of the pulse counter and thresholds
//   WIN_LOG2 window length is 2^WIN_LOG2 clk cycles (2..20)
//   DEB      consecutive qualifying windows needed to toggle temp_warn (1..15)
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   en          measurement enable; low holds counters at 0
//   osc_pulse   one-cycle pulse per oscillator edge (already synchronised)
//   thr_set     temp_warn set condition: count < thr_set
//   thr_clr     temp_warn clear condition: count > thr_clr
//   count_out   last completed window count
//   count_valid one-cycle strobe, count_out just updated
//   temp_warn   over-temperature flag
//
// Build option: define OSC_WARN_STICKY_EN to make temp_warn sticky once set
// (only rst_n clears it). Counting is identical in both builds.

`timescale 1ns/1ps

module osc_window_hyst #(
  parameter int CNT_W    = 16,
  parameter int WIN_LOG2 = 12,
  parameter int DEB      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             osc_pulse,
  input  logic [CNT_W-1:0] thr_set,
  input  logic [CNT_W-1:0] thr_clr,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             temp_warn
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_SET   = 1'b1;

  localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]    CNT_ZERO = '0;
  localparam logic [WIN_LOG2-1:0] WIN_LAST = '1;
  localparam logic [WIN_LOG2-1:0] WIN_ONE  = 1;
  localparam logic [3:0]          DEB_L    = 4'(DEB);

  logic [WIN_LOG2-1:0] win_cnt_reg;
  logic [CNT_W-1:0]    pulse_cnt_reg;
  logic [CNT_W-1:0]    pulse_cnt_next;
  logic [CNT_W-1:0]    count_out_reg;
  logic                valid_reg;
  logic [0:0]          state_reg, state_next;
  logic [3:0]          streak_reg, streak_next;
  logic [3:0]          streak_inc;
  logic                terminal;
  logic                evaluate;

  // Terminal cycle only counts when en is sampled high in it.
  assign terminal = en && (win_cnt_reg == WIN_LAST);

  // Saturating add of the current pulse; used both for the running count and
  // for the published value so a terminal-cycle pulse is included.
  assign pulse_cnt_next = (osc_pulse && (pulse_cnt_reg != CNT_MAX))
                        ? pulse_cnt_reg + {CNT_ZERO[CNT_W-1:1], 1'b1}
                        : pulse_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_reg   <= '0;
      pulse_cnt_reg <= '0;
      count_out_reg <= '0;
      valid_reg     <= 1'b0;
    end else if (!en) begin
      win_cnt_reg   <= '0;
      pulse_cnt_reg <= '0;
      valid_reg     <= 1'b0;
    end else begin
      win_cnt_reg <= win_cnt_reg + WIN_ONE;
      valid_reg   <= terminal;
      if (terminal) begin
        count_out_reg <= pulse_cnt_next;
        pulse_cnt_reg <= '0;
      end else begin
        pulse_cnt_reg <= pulse_cnt_next;
      end
    end
  end

  // The strobe is forced low while en is low; the hysteresis only evaluates
  // on a strobe that is actually presented.
  assign count_valid = valid_reg && en;
  assign evaluate    = count_valid;
  assign streak_inc  = streak_reg + 4'd1;

  always_comb begin
    state_next  = state_reg;
    streak_next = streak_reg;
    if (evaluate) begin
      if (state_reg == ST_CLEAR) begin
        if (count_out_reg < thr_set) begin
          if (streak_inc == DEB_L) begin
            state_next  = ST_SET;
            streak_next = 4'd0;
          end else begin
            streak_next = streak_inc;
          end
        end else begin
          streak_next = 4'd0;
        end
      end else begin
`ifdef OSC_WARN_STICKY_EN
        streak_next = 4'd0;
`else
        if (count_out_reg > thr_clr) begin
          if (streak_inc == DEB_L) begin
            state_next  = ST_CLEAR;
            streak_next = 4'd0;
          end else begin
            streak_next = streak_inc;
          end
        end else begin
          streak_next = 4'd0;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_CLEAR;
      streak_reg <= 4'd0;
    end else begin
      state_reg  <= state_next;
      streak_reg <= streak_next;
    end
  end

  assign count_out = count_out_reg;
  assign temp_warn = (state_reg == ST_SET);

endmodule
